// File: rtl/hash_mem_responder.sv
// Word-memory responder for the hasher: one-cycle read port, host preload/readback port,
// and a per-session monitor tracking the minimum H0 written into the nonce output window.
module hash_mem_responder #(
    parameter int DEPTH     = 256,
    parameter int NUM_NONCE = 16,
    parameter int NONCE_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_we,
    input  logic [15:0]        mem_addr,
    input  logic [31:0]        mem_write_data,
    output logic [31:0]        mem_read_data,
    input  logic               host_valid,
    output logic               host_ready,
    input  logic               host_we,
    input  logic [15:0]        host_addr,
    input  logic [31:0]        host_wdata,
    output logic [31:0]        host_rdata,
    output logic               host_rvalid,
    input  logic               session_start,
    input  logic               session_done,
    input  logic [15:0]        output_addr,
    output logic               result_valid,
    output logic [31:0]        best_h0,
    output logic [NONCE_W-1:0] best_nonce,
    output logic [NONCE_W:0]   write_count,
    output logic               err_oob,
    output logic               err_dup
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_REPORT} state_t;

    logic [31:0]          r_mem [DEPTH];
    state_t               r_state;
    logic [15:0]          r_out_base;
    logic [NUM_NONCE-1:0] r_bitmap;
    logic [31:0]          r_mem_rdata;
    logic [31:0]          r_host_rdata;
    logic                 r_host_rvalid;
    logic                 r_host_ready;
    logic                 r_result_valid;
    logic [31:0]          r_best_h0;
    logic [NONCE_W-1:0]   r_best_nonce;
    logic [NONCE_W:0]     r_write_count;
    logic                 r_err_oob;
    logic                 r_err_dup;

    logic                 w_mem_oob;
    logic                 w_host_oob;
    logic [AW-1:0]        w_mem_idx;
    logic [AW-1:0]        w_host_idx;
    logic                 w_host_acc;
    logic [16:0]          w_win_off;
    logic                 w_win_hit;
    logic [NONCE_W-1:0]   w_idx;
    logic                 w_new;
    logic                 w_dup;
    logic [NONCE_W:0]     w_count_next;

    assign w_mem_oob    = {1'b0, mem_addr} >= 17'(DEPTH);
    assign w_host_oob   = {1'b0, host_addr} >= 17'(DEPTH);
    assign w_mem_idx    = mem_addr[AW-1:0];
    assign w_host_idx   = host_addr[AW-1:0];
    assign w_host_acc   = host_valid && r_host_ready;

    // 17-bit difference: addresses below the base land at >= 2^16 and never hit
    assign w_win_off    = {1'b0, mem_addr} - {1'b0, r_out_base};
    assign w_win_hit    = (r_state == S_BUSY) && mem_we && (w_win_off < 17'(NUM_NONCE));
    assign w_idx        = w_win_off[NONCE_W-1:0];
    assign w_new        = w_win_hit && !r_bitmap[w_idx];
    assign w_dup        = w_win_hit && r_bitmap[w_idx];
    assign w_count_next = r_write_count + {{NONCE_W{1'b0}}, w_new};

    // Hasher write is issued last so it wins a same-address collision with the host
    always_ff @(posedge clk) begin
        if (w_host_acc && host_we && !w_host_oob)
            r_mem[w_host_idx] <= host_wdata;
        if (mem_we && !w_mem_oob)
            r_mem[w_mem_idx] <= mem_write_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_out_base     <= '0;
            r_bitmap       <= '0;
            r_mem_rdata    <= '0;
            r_host_rdata   <= '0;
            r_host_rvalid  <= 1'b0;
            r_host_ready   <= 1'b1;
            r_result_valid <= 1'b0;
            r_best_h0      <= 32'hFFFF_FFFF;
            r_best_nonce   <= '0;
            r_write_count  <= '0;
            r_err_oob      <= 1'b0;
            r_err_dup      <= 1'b0;
        end else begin
            r_mem_rdata   <= w_mem_oob ? 32'h0 : r_mem[w_mem_idx];
            r_host_rvalid <= w_host_acc && !host_we;
            if (w_host_acc && !host_we)
                r_host_rdata <= w_host_oob ? 32'h0 : r_mem[w_host_idx];
            r_err_oob <= r_err_oob | w_mem_oob | (w_host_acc & w_host_oob);
            r_err_dup <= r_err_dup | w_dup;

            case (r_state)
                S_IDLE, S_REPORT: begin
                    if (session_start) begin
                        r_state        <= S_BUSY;
                        r_host_ready   <= 1'b0;
                        r_out_base     <= output_addr;
                        r_bitmap       <= '0;
                        r_write_count  <= '0;
                        r_result_valid <= 1'b0;
                        r_best_h0      <= 32'hFFFF_FFFF;
                        r_best_nonce   <= '0;
                    end
                end
                S_BUSY: begin
                    if (w_new) begin
                        r_bitmap[w_idx] <= 1'b1;
                        r_write_count   <= w_count_next;
                        if (mem_write_data < r_best_h0) begin
                            r_best_h0    <= mem_write_data;
                            r_best_nonce <= w_idx;
                        end
                    end
                    if (session_done) begin
                        r_state        <= S_REPORT;
                        r_host_ready   <= 1'b1;
                        r_result_valid <= (w_count_next == (NONCE_W+1)'(NUM_NONCE));
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_host_ready <= 1'b1;
                end
            endcase
        end
    end

    assign mem_read_data = r_mem_rdata;
    assign host_ready    = r_host_ready;
    assign host_rdata    = r_host_rdata;
    assign host_rvalid   = r_host_rvalid;
    assign result_valid  = r_result_valid;
    assign best_h0       = r_best_h0;
    assign best_nonce    = r_best_nonce;
    assign write_count   = r_write_count;
    assign err_oob       = r_err_oob;
    assign err_dup       = r_err_dup;
endmodule

// File: tb/tb_hash_mem_responder.sv
// Directed bench for hash_mem_responder: host preload, sessions, ties, duplicates,
// partial sessions, out-of-range accesses and mid-session reset.
module tb_hash_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        host_valid;
    logic        host_ready;
    logic        host_we;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_rvalid;
    logic        session_start;
    logic        session_done;
    logic [15:0] output_addr;
    logic        result_valid;
    logic [31:0] best_h0;
    logic [3:0]  best_nonce;
    logic [4:0]  write_count;
    logic        err_oob;
    logic        err_dup;

    int n_cmp = 0;
    int n_err = 0;

    hash_mem_responder dut (
        .clk(clk), .reset(reset),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid),
        .session_start(session_start), .session_done(session_done),
        .output_addr(output_addr),
        .result_valid(result_valid), .best_h0(best_h0), .best_nonce(best_nonce),
        .write_count(write_count), .err_oob(err_oob), .err_dup(err_dup)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hasher_write(input logic [15:0] a, input logic [31:0] d);
        mem_we = 1'b1; mem_addr = a; mem_write_data = d;
        tick();
        mem_we = 1'b0; mem_addr = 16'h0;
    endtask

    task automatic host_write(input logic [15:0] a, input logic [31:0] d);
        host_valid = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        tick();
        host_valid = 1'b0; host_we = 1'b0;
    endtask

    task automatic start_session(input logic [15:0] base);
        session_start = 1'b1; output_addr = base;
        tick();
        session_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (mem_read_data !== 32'h0) begin
            n_err++; $display("FAIL reset_mem_rdata: got %h want 00000000", mem_read_data);
        end
        reset = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (host_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_host_ready: got %b want 1", host_ready);
        end
        n_cmp++;
        if (best_h0 !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL reset_best_h0: got %h want ffffffff", best_h0);
        end
        n_cmp++;
        if ({result_valid, best_nonce, write_count, err_oob, err_dup, host_rvalid} !== 13'h0
            || host_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_zero_outputs: rv=%b nonce=%h wc=%0d oob=%b dup=%b rvalid=%b rdata=%h want all 0",
                     result_valid, best_nonce, write_count, err_oob, err_dup, host_rvalid, host_rdata);
        end
    endtask

    task automatic test_host_preload();
        for (int i = 0; i < 19; i++) host_write(16'(i), 32'h1000 + 32'(i));
        host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h05;
        tick();
        host_valid = 1'b0;
        n_cmp++;
        if (host_rvalid !== 1'b1 || host_rdata !== 32'h1005) begin
            n_err++; $display("FAIL host_read: rvalid=%b rdata=%h want 1 / 00001005", host_rvalid, host_rdata);
        end
        tick();
        n_cmp++;
        if (host_rvalid !== 1'b0) begin
            n_err++; $display("FAIL host_rvalid_pulse: got %b want 0", host_rvalid);
        end
        mem_addr = 16'h12;
        tick();
        mem_addr = 16'h0;
        n_cmp++;
        if (mem_read_data !== 32'h1012) begin
            n_err++; $display("FAIL hasher_read: got %h want 00001012", mem_read_data);
        end
    endtask

    task automatic test_session();
        start_session(16'h80);
        n_cmp++;
        if (host_ready !== 1'b0) begin
            n_err++; $display("FAIL busy_host_ready: got %b want 0", host_ready);
        end
        for (int i = 0; i < 16; i++)
            hasher_write(16'h80 + 16'(i), (i == 7) ? 32'h42 : 32'h9000_0000 - 32'(i) * 32'h100);
        session_done = 1'b1;
        tick();
        session_done = 1'b0;
        n_cmp++;
        if (result_valid !== 1'b1 || best_h0 !== 32'h42 || best_nonce !== 4'd7 || write_count !== 5'd16) begin
            n_err++;
            $display("FAIL session_result: rv=%b h0=%h nonce=%0d wc=%0d want 1 / 00000042 / 7 / 16",
                     result_valid, best_h0, best_nonce, write_count);
        end
        n_cmp++;
        if (host_ready !== 1'b1 || err_dup !== 1'b0) begin
            n_err++; $display("FAIL report_state: host_ready=%b err_dup=%b want 1 / 0", host_ready, err_dup);
        end
        mem_addr = 16'h8F;
        tick();
        mem_addr = 16'h0;
        n_cmp++;
        if (mem_read_data !== 32'h9000_0000 - 32'hF00) begin
            n_err++; $display("FAIL window_stored: got %h want 8ffff100", mem_read_data);
        end
    endtask

    // Last window write lands in the same cycle as session_done
    task automatic test_tie_dup();
        start_session(16'h40);
        for (int i = 0; i < 15; i++)
            hasher_write(16'h40 + 16'(i), (i == 3 || i == 9) ? 32'h10 : 32'h100 + 32'(i));
        hasher_write(16'h43, 32'h5);
        n_cmp++;
        if (err_dup !== 1'b1 || write_count !== 5'd15) begin
            n_err++; $display("FAIL dup_write: err_dup=%b wc=%0d want 1 / 15", err_dup, write_count);
        end
        mem_we = 1'b1; mem_addr = 16'h4F; mem_write_data = 32'h10F; session_done = 1'b1;
        tick();
        mem_we = 1'b0; mem_addr = 16'h0; session_done = 1'b0;
        n_cmp++;
        if (result_valid !== 1'b1 || write_count !== 5'd16) begin
            n_err++; $display("FAIL same_cycle_done: rv=%b wc=%0d want 1 / 16", result_valid, write_count);
        end
        n_cmp++;
        if (best_h0 !== 32'h10 || best_nonce !== 4'd3) begin
            n_err++; $display("FAIL tie_keep_first: h0=%h nonce=%0d want 00000010 / 3", best_h0, best_nonce);
        end
    endtask

    task automatic test_partial();
        start_session(16'hA0);
        host_valid = 1'b1; host_we = 1'b1; host_addr = 16'h05; host_wdata = 32'hDEAD;
        for (int i = 0; i < 15; i++) hasher_write(16'hA0 + 16'(i), 32'h200 + 32'(i));
        host_valid = 1'b0; host_we = 1'b0;
        n_cmp++;
        if (host_ready !== 1'b0 || host_rvalid !== 1'b0) begin
            n_err++; $display("FAIL busy_blocks_host: ready=%b rvalid=%b want 0 / 0", host_ready, host_rvalid);
        end
        session_done = 1'b1;
        tick();
        session_done = 1'b0;
        n_cmp++;
        if (result_valid !== 1'b0 || write_count !== 5'd15 || best_h0 !== 32'h200 || best_nonce !== 4'd0) begin
            n_err++;
            $display("FAIL partial_session: rv=%b wc=%0d h0=%h nonce=%0d want 0 / 15 / 00000200 / 0",
                     result_valid, write_count, best_h0, best_nonce);
        end
        n_cmp++;
        if (host_ready !== 1'b1) begin
            n_err++; $display("FAIL partial_report_ready: got %b want 1", host_ready);
        end
        host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h05;
        tick();
        host_valid = 1'b0;
        n_cmp++;
        if (host_rvalid !== 1'b1 || host_rdata !== 32'h1005) begin
            n_err++; $display("FAIL busy_write_dropped: rvalid=%b rdata=%h want 1 / 00001005", host_rvalid, host_rdata);
        end
    endtask

    task automatic test_oob_and_abort();
        n_cmp++;
        if (err_oob !== 1'b0) begin
            n_err++; $display("FAIL oob_initial: got %b want 0", err_oob);
        end
        mem_we = 1'b1; mem_addr = 16'h0100; mem_write_data = 32'h1234;
        tick();
        mem_we = 1'b0; mem_addr = 16'h0;
        n_cmp++;
        if (mem_read_data !== 32'h0 || err_oob !== 1'b1) begin
            n_err++; $display("FAIL oob_access: rdata=%h oob=%b want 00000000 / 1", mem_read_data, err_oob);
        end
        tick();
        n_cmp++;
        if (mem_read_data !== 32'h1000 || err_oob !== 1'b1) begin
            n_err++; $display("FAIL oob_sticky_no_alias: rdata=%h oob=%b want 00001000 / 1", mem_read_data, err_oob);
        end
        start_session(16'h80);
        hasher_write(16'h80, 32'h7);
        hasher_write(16'h81, 32'h8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (host_ready !== 1'b1 || write_count !== 5'd0 || err_oob !== 1'b0 || err_dup !== 1'b0
            || best_h0 !== 32'hFFFF_FFFF || result_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_reset: ready=%b wc=%0d oob=%b dup=%b h0=%h rv=%b want 1 / 0 / 0 / 0 / ffffffff / 0",
                     host_ready, write_count, err_oob, err_dup, best_h0, result_valid);
        end
        host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h12;
        tick();
        host_valid = 1'b0;
        n_cmp++;
        if (host_rvalid !== 1'b1 || host_rdata !== 32'h1012) begin
            n_err++; $display("FAIL abort_idle_host: rvalid=%b rdata=%h want 1 / 00001012", host_rvalid, host_rdata);
        end
    endtask

    initial begin
        reset = 1'b1; mem_we = 1'b0; mem_addr = 16'h0; mem_write_data = 32'h0;
        host_valid = 1'b0; host_we = 1'b0; host_addr = 16'h0; host_wdata = 32'h0;
        session_start = 1'b0; session_done = 1'b0; output_addr = 16'h0;
        test_reset();
        test_host_preload();
        test_session();
        test_tie_dup();
        test_partial();
        test_oob_and_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
